// File: rtl/rr_sel_arbiter_2x4_if.sv
// Request/select bundle between requesters, the round-robin arbiter and the 2x4 decoder.
interface rr_sel_arbiter_2x4_if;
    logic [3:0] req;
    logic       done;
    logic [2:0] a;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  a,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output a,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_sel_arbiter_2x4.sv
// Round-robin arbiter producing a registered {enable, index} code for the 2x4 decoder.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces release after MAX_GRANT cycles.
//
// state | meaning
// IDLE  | no owner; a[2]=0, a[1:0] keeps the last index
// GRANT | owner a[1:0] holds the grant until done, request drop or timeout
module rr_sel_arbiter_2x4 #(
    parameter int MAX_GRANT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_sel_arbiter_2x4_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (MAX_GRANT < 1 || MAX_GRANT > 255) begin : g_bad_max_grant
        $error("MAX_GRANT must lie in 1..255");
    end

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] last_q, last_d;
    logic       busy_q, busy_d;
    logic       nat_release;
    logic       tmo_hit;
    logic [2:0] pick;

    // Returns {found, index}; search begins one past the last owner and wraps.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = last + 2'(i + 1);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign nat_release = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign tmo_hit = (state_q == GRANT) && (cnt_q == 8'(MAX_GRANT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // The owner's own bit is masked on release so a lone requester sees one idle cycle.
    assign pick = (state_q == IDLE) ? rr_pick(bus.req, last_q)
                                    : rr_pick(bus.req & ~(4'b0001 << idx_q), last_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (pick[2]) begin
                    state_d = GRANT;
                    idx_d   = pick[1:0];
                    last_d  = pick[1:0];
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (nat_release || tmo_hit) begin
`ifdef ARB_TIMEOUT_EN
                    timeout_d = ~nat_release;
`endif
                    if (pick[2]) begin
                        idx_d  = pick[1:0];
                        last_d = pick[1:0];
`ifdef ARB_TIMEOUT_EN
                        cnt_d  = 8'd0;
`endif
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // Enable is the registered busy flag, so a[2]==busy by construction.
    assign bus.a    = {busy_q, idx_q};
    assign bus.busy = busy_q;

endmodule
